instr_sequencer: RTL and testbench

//  Hardware instruction source for Processor; it replaces bench-driven stimulus.

---
 rtl/vp_pkg.sv | 46 ++++
 rtl/instr_prog_mem.sv | 37 +++
 rtl/instr_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vp_pkg.sv
// -----------------------------------------------------------------------------
// vp_pkg
// Shared definitions for the instruction sequencer that feeds the Processor.
//  - INSTR_W         : width of one vector instruction word (13 bits)
//  - OP_*            : opcode encodings held in bits [12:11]
//  - *_MSB / *_LSB   : field boundaries (opcode 12:11, reg 10:9, addr 8:0)
//  - state_t         : sequencer FSM state encoding
//  - issue_word()    : word as placed on the bus (ADD/MUL carry no operands)
// -----------------------------------------------------------------------------
package vp_pkg;

   localparam int INSTR_W = 13;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_STORE = 2'b01;
   localparam logic [1:0] OP_ADD   = 2'b10;
   localparam logic [1:0] OP_MUL   = 2'b11;

   localparam int OPC_MSB  = 12;
   localparam int OPC_LSB  = 11;
   localparam int REG_MSB  = 10;
   localparam int REG_LSB  = 9;
   localparam int ADDR_MSB = 8;
   localparam int ADDR_LSB = 0;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRST  = 3'd1,
      ST_ISSUE = 3'd2,
      ST_HOLD  = 3'd3,
      ST_FIN   = 3'd4
   } state_t;

   // ADD and MUL work on fixed registers, so their reg/addr fields are
   // cleared before the word reaches the Processor.
   function automatic logic [INSTR_W-1:0] issue_word(input logic [INSTR_W-1:0] w);
      logic [1:0] op;
      op = w[OPC_MSB:OPC_LSB];
      if ((op == OP_ADD) || (op == OP_MUL)) begin
         return {op, {(REG_MSB-ADDR_LSB+1){1'b0}}};
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/instr_prog_mem.sv
// -----------------------------------------------------------------------------
// instr_prog_mem
// DEPTH x INSTR_W program store. Synchronous write, asynchronous read,
// contents are deliberately not reset so a program survives a reset.
// Ports:
//  clk    in   clock
//  we     in   write strobe
//  waddr  in   write slot
//  wdata  in   instruction word to store
//  raddr  in   read slot
//  rdata  out  word at raddr (combinational)
// -----------------------------------------------------------------------------
module instr_prog_mem
   import vp_pkg::*;
#(
   parameter int DEPTH = 16
)(
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [INSTR_W-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [INSTR_W-1:0]       rdata
);

   logic [INSTR_W-1:0] mem_r [DEPTH];

   // Program write port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Hardware instruction source for the Processor. On start it pulses the
// Processor reset, then plays the stored program word by word, each word held
// on the bus for its opcode's hold time, and finally pulses done.
// Ports:
//  clk          in   clock, rising edge
//  rst          in   asynchronous active-low reset
//  prog_we      in   program write strobe (honoured only while idle)
//  prog_addr    in   program slot to write
//  prog_data    in   instruction word to write
//  prog_len     in   number of instructions to run, sampled on start
//  start        in   run request
//  abort        in   synchronous cancel of a run
//  instruction  out  instruction bus to the Processor
//  instr_valid  out  instruction carries a program word
//  proc_rst     out  active-high reset pulse to the Processor
//  busy         out  run in progress
//  done         out  one-cycle pulse at the end of a completed run
//  pc           out  index of the word on the bus
// -----------------------------------------------------------------------------
module instr_sequencer
   import vp_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int HOLD_LD  = 10,
   parameter int HOLD_ST  = 10,
   parameter int HOLD_ADD = 10,
   parameter int HOLD_MUL = 10,
   parameter int CNT_W    = 8
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     prog_we,
   input  logic [$clog2(DEPTH)-1:0] prog_addr,
   input  logic [INSTR_W-1:0]       prog_data,
   input  logic [$clog2(DEPTH):0]   prog_len,
   input  logic                     start,
   input  logic                     abort,
   output logic [INSTR_W-1:0]       instruction,
   output logic                     instr_valid,
   output logic                     proc_rst,
   output logic                     busy,
   output logic                     done,
   output logic [$clog2(DEPTH)-1:0] pc
);

   localparam int             AW      = $clog2(DEPTH);
   localparam int             LW      = AW + 1;
   localparam logic [LW-1:0]  LEN_MAX = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

   // Hold time for an opcode; a zero hold still occupies one bus cycle.
   function automatic logic [CNT_W-1:0] hold_for(input logic [1:0] op);
      int unsigned h;
      case (op)
         OP_LOAD:  h = HOLD_LD;
         OP_STORE: h = HOLD_ST;
         OP_ADD:   h = HOLD_ADD;
         OP_MUL:   h = HOLD_MUL;
         default:  h = HOLD_MUL;
      endcase
      return (h == 32'd0) ? CNT_ONE : h[CNT_W-1:0];
   endfunction

   state_t               state_r, state_s;
   logic [AW-1:0]        pc_r, pc_s;
   logic [LW-1:0]        len_r, len_s, len_sat_s;
   logic [CNT_W-1:0]     cnt_r, cnt_s, hold_s;
   logic [INSTR_W-1:0]   instruction_r, instr_s;
   logic                 instr_valid_r, valid_s;
   logic                 proc_rst_r, prst_s;
   logic                 busy_r, busy_s;
   logic                 done_r, done_s;
   logic                 mem_we_s;
   logic [AW-1:0]        rd_addr_s;
   logic [INSTR_W-1:0]   rd_data_s, word_s;

   instr_prog_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (mem_we_s),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (rd_addr_s),
      .rdata (rd_data_s)
   );

   // Read address: while holding, look ahead to the next word so it can be
   // placed on the bus on the very edge the current hold expires.
   always_comb begin
      if (state_r == ST_HOLD) begin
         rd_addr_s = pc_r + AW'(1'b1);
      end else begin
         rd_addr_s = pc_r;
      end
   end

   // Run length limited to the program size.
   always_comb begin
      if (prog_len > LEN_MAX) begin
         len_sat_s = LEN_MAX;
      end else begin
         len_sat_s = prog_len;
      end
   end

   assign word_s = issue_word(rd_data_s);
   assign hold_s = hold_for(rd_data_s[OPC_MSB:OPC_LSB]);

   // Next-state and next-output decode; outputs are registered from these.
   always_comb begin
      state_s  = state_r;
      pc_s     = pc_r;
      len_s    = len_r;
      cnt_s    = cnt_r;
      instr_s  = instruction_r;
      valid_s  = instr_valid_r;
      prst_s   = 1'b0;
      busy_s   = busy_r;
      done_s   = 1'b0;
      mem_we_s = 1'b0;
      if (abort && (state_r != ST_IDLE)) begin
         state_s = ST_IDLE;
         valid_s = 1'b0;
         busy_s  = 1'b0;
         pc_s    = {AW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               mem_we_s = prog_we;
               if (start) begin
                  if (prog_len != {LW{1'b0}}) begin
                     state_s = ST_PRST;
                     len_s   = len_sat_s;
                     prst_s  = 1'b1;
                     busy_s  = 1'b1;
                  end else begin
                     state_s = ST_FIN;
                     done_s  = 1'b1;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_PRST: begin
               state_s = ST_ISSUE;
            end
            ST_ISSUE: begin
               instr_s = word_s;
               valid_s = 1'b1;
               cnt_s   = hold_s;
               state_s = ST_HOLD;
            end
            ST_HOLD: begin
               if (cnt_r == CNT_ONE) begin
                  if ({1'b0, pc_r} == (len_r - LW'(1'b1))) begin
                     state_s = ST_FIN;
                     done_s  = 1'b1;
                     valid_s = 1'b0;
                     busy_s  = 1'b0;
                     pc_s    = {AW{1'b0}};
                  end else begin
                     // The expiring hold cycle doubles as the issue slot of
                     // the next word, so consecutive words have no gap.
                     pc_s    = rd_addr_s;
                     instr_s = word_s;
                     cnt_s   = hold_s;
                     state_s = ST_HOLD;
                  end
               end else begin
                  cnt_s = cnt_r - CNT_ONE;
               end
            end
            ST_FIN: begin
               state_s = ST_IDLE;
            end
            default: begin
               state_s = ST_IDLE;
               valid_s = 1'b0;
               busy_s  = 1'b0;
               pc_s    = {AW{1'b0}};
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= ST_IDLE;
         pc_r          <= {AW{1'b0}};
         len_r         <= {LW{1'b0}};
         cnt_r         <= {CNT_W{1'b0}};
         instruction_r <= {INSTR_W{1'b0}};
         instr_valid_r <= 1'b0;
         proc_rst_r    <= 1'b0;
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         len_r         <= len_s;
         cnt_r         <= cnt_s;
         instruction_r <= instr_s;
         instr_valid_r <= valid_s;
         proc_rst_r    <= prst_s;
         busy_r        <= busy_s;
         done_r        <= done_s;
      end
   end

   assign instruction = instruction_r;
   assign instr_valid = instr_valid_r;
   assign proc_rst    = proc_rst_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign pc          = pc_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Scoreboard bench: stimulus pushes the expected bus events (proc_rst pulse,
// each word's appearance with pc/start cycle/duration, done pulse) into a
// queue; a monitor on the falling edge reconstructs the events from the DUT
// outputs and compares them in order. Cycle index k = cycle after edge E_k,
// where E_0 is the edge that samples start.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

   localparam int EV_PRST = 0;
   localparam int EV_WORD = 1;
   localparam int EV_DONE = 2;

   typedef struct {
      int          kind;
      logic [12:0] word;
      int          pc;
      int          k;
      int          len;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [12:0] prog_data;
   logic [4:0]  prog_len;
   logic        start;
   logic        abort;
   logic [12:0] instruction;
   logic        instr_valid;
   logic        proc_rst;
   logic        busy;
   logic        done;
   logic [3:0]  pc;

   int    checks = 0;
   int    passed = 0;
   time   start_t = 0;
   ev_t   exp_q[$];
   logic [12:0] prog [16];

   always #5 clk = ~clk;

   instr_sequencer #(
      .DEPTH(16), .HOLD_LD(10), .HOLD_ST(10), .HOLD_ADD(10), .HOLD_MUL(3), .CNT_W(8)
   ) dut (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
      .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
      .instruction(instruction), .instr_valid(instr_valid), .proc_rst(proc_rst),
      .busy(busy), .done(done), .pc(pc)
   );

   task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic push(input int kind, input logic [12:0] w, input int p, input int k, input int len);
      ev_t e;
      e.kind = kind; e.word = w; e.pc = p; e.k = k; e.len = len;
      exp_q.push_back(e);
   endtask

   // Expected events of a full run over the first n program slots.
   task automatic expect_run(input int n);
      int k;
      logic [1:0] op;
      logic [12:0] w;
      push(EV_PRST, 13'h0000, 0, 0, 1);
      k = 2;
      for (int i = 0; i < n; i++) begin
         w  = prog[i];
         op = w[12:11];
         push(EV_WORD, op[1] ? {op, 11'h000} : w, i, k, (op == 2'b11) ? 3 : 10);
         k += (op == 2'b11) ? 3 : 10;
      end
      push(EV_DONE, 13'h0000, 0, k, 1);
   endtask

   task automatic emit(input int kind, input logic [12:0] w, input int p, input int k, input int len);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         $display("FAIL event: unexpected kind=%0d word=%h pc=%0d k=%0d len=%0d", kind, w, p, k, len);
      end else begin
         e = exp_q.pop_front();
         if (e.kind === kind && e.word === w && e.pc == p && e.k == k && e.len == len)
            passed++;
         else
            $display("FAIL event: got kind=%0d word=%h pc=%0d k=%0d len=%0d expected kind=%0d word=%h pc=%0d k=%0d len=%0d",
                     kind, w, p, k, len, e.kind, e.word, e.pc, e.k, e.len);
      end
   endtask

   // Monitor state
   bit          prst_prev = 1'b0, done_prev = 1'b0, seg_on = 1'b0;
   int          prst_k = 0, done_k = 0, seg_k = 0, seg_pc = 0;
   logic [12:0] seg_word = 13'h0000;

   // Monitor: turn output waveforms into events and hand them to the scoreboard.
   always @(negedge clk) begin
      int k;
      k = int'((longint'($time) - longint'(start_t) - 64'sd5) / 64'sd10);
      if (proc_rst === 1'b1 && !prst_prev) prst_k = k;
      else if (proc_rst !== 1'b1 && prst_prev) emit(EV_PRST, 13'h0000, 0, prst_k, k - prst_k);
      prst_prev = (proc_rst === 1'b1);
      if (done === 1'b1 && !done_prev) done_k = k;
      else if (done !== 1'b1 && done_prev) emit(EV_DONE, 13'h0000, 0, done_k, k - done_k);
      done_prev = (done === 1'b1);
      if (seg_on && (instr_valid !== 1'b1 || instruction !== seg_word || int'(pc) != seg_pc)) begin
         emit(EV_WORD, seg_word, seg_pc, seg_k, k - seg_k);
         seg_on = 1'b0;
      end
      if (instr_valid === 1'b1 && !seg_on) begin
         seg_on = 1'b1; seg_word = instruction; seg_pc = int'(pc); seg_k = k;
      end
   end

   task automatic write_word(input logic [3:0] a, input logic [12:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_data = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   // Issue start (optionally with a same-edge program write); returns at the
   // falling edge after the start edge.
   task automatic start_run(input logic [4:0] len, input logic we, input logic [3:0] a, input logic [12:0] d);
      @(negedge clk);
      prog_len = len; start = 1'b1; prog_we = we; prog_addr = a; prog_data = d;
      @(posedge clk);
      start_t = $time;
      @(negedge clk);
      start = 1'b0; prog_we = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_instruction"}, 32'(instruction), 32'h0);
      check_val({tag, "_instr_valid"}, 32'(instr_valid), 32'h0);
      check_val({tag, "_proc_rst"},    32'(proc_rst),    32'h0);
      check_val({tag, "_busy"},        32'(busy),        32'h0);
      check_val({tag, "_done"},        32'(done),        32'h0);
      check_val({tag, "_pc"},          32'(pc),          32'h0);
   endtask

   initial begin
      rst = 1'b1; prog_we = 1'b0; prog_addr = 4'h0; prog_data = 13'h0000;
      prog_len = 5'd0; start = 1'b0; abort = 1'b0;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #2 rst = 1'b1;

      // Program image
      prog[0] = 13'h0000; prog[1] = 13'h0201; prog[2] = 13'h1000; prog[3] = 13'h0C02;
      prog[4] = 13'h1ABC;
      for (int i = 5; i < 15; i++) prog[i] = {2'b01, 2'(i % 4), 9'(i * 7)};
      prog[15] = 13'h1555;
      for (int i = 0; i < 16; i++) write_word(4'(i), prog[i]);

      // Four-word program, done 42 cycles after start
      expect_run(4);
      start_run(5'd4, 1'b0, 4'h0, 13'h0000);
      repeat (50) @(negedge clk);
      check_val("post_busy", 32'(busy), 32'h0);
      check_val("post_valid", 32'(instr_valid), 32'h0);
      check_val("post_pc", 32'(pc), 32'h0);
      check_val("post_instruction_kept", 32'(instruction), 32'h0C02);

      // MUL with short hold, written on the same edge as start
      prog[0] = 13'h1ABC;
      expect_run(1);
      start_run(5'd1, 1'b1, 4'h0, 13'h1ABC);
      repeat (10) @(negedge clk);
      prog[0] = 13'h0000;
      write_word(4'h0, 13'h0000);

      // Zero-length run: only a done pulse
      push(EV_DONE, 13'h0000, 0, 0, 1);
      start_run(5'd0, 1'b0, 4'h0, 13'h0000);
      repeat (6) @(negedge clk);

      // start + prog_we while busy are ignored; rerun shows memory unchanged
      expect_run(2);
      start_run(5'd2, 1'b0, 4'h0, 13'h0000);
      repeat (7) @(negedge clk);
      prog_we = 1'b1; prog_addr = 4'h1; prog_data = 13'h1FFF; prog_len = 5'd1; start = 1'b1;
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      repeat (25) @(negedge clk);
      expect_run(2);
      start_run(5'd2, 1'b0, 4'h0, 13'h0000);
      repeat (30) @(negedge clk);

      // Abort in the 5th cycle of instruction 2
      push(EV_PRST, 13'h0000, 0, 0, 1);
      push(EV_WORD, 13'h0000, 0, 2, 10);
      push(EV_WORD, 13'h0201, 1, 12, 5);
      start_run(5'd4, 1'b0, 4'h0, 13'h0000);
      repeat (16) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("abort_busy", 32'(busy), 32'h0);
      check_val("abort_pc", 32'(pc), 32'h0);
      check_val("abort_valid", 32'(instr_valid), 32'h0);
      check_val("abort_done", 32'(done), 32'h0);
      repeat (40) @(negedge clk);

      // Async reset mid-hold, then a clean rerun from pc 0
      push(EV_PRST, 13'h0000, 0, 0, 1);
      push(EV_WORD, 13'h0000, 0, 2, 4);
      start_run(5'd4, 1'b0, 4'h0, 13'h0000);
      repeat (5) @(negedge clk);
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      check_all_zero("midrun_reset");
      @(posedge clk); #2 rst = 1'b1;
      expect_run(4);
      start_run(5'd4, 1'b0, 4'h0, 13'h0000);
      repeat (50) @(negedge clk);

      // Length above DEPTH saturates to all 16 slots
      expect_run(16);
      start_run(5'd20, 1'b0, 4'h0, 13'h0000);
      repeat (170) @(negedge clk);

      check_val("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
